// File: rtl/log_adder_pipe_pkg.sv
// Shared types for the Mitchell multiplier log-domain adder.
// T is the log-sum fraction width; operand fractions are one bit narrower.
`ifndef T
`define T 8
`endif

package log_adder_pipe_pkg;

  localparam int T   = `T;
  localparam int K_W = 4;

  typedef struct packed {
    logic [2:0]   k;
    logic [T-2:0] frac;
    logic         sign;
    logic         zero;
  } log_operand_t;

  typedef struct packed {
    logic [T+3:0] log_result;
    logic         sign;
    logic         zero;
  } log_prod_t;

endpackage

// File: rtl/log_adder_pipe_reg_stage.sv
// Valid/ready-gated register stage holding one log product and its tag.
module pipe_reg_stage
  import log_adder_pipe_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
  input  logic            in_vld,
  input  log_prod_t       in_data,
  input  logic [ID_W-1:0] in_id,
  output logic            vld,
  output log_prod_t       data,
  output logic [ID_W-1:0] id
);

  // Data only moves on a real load so held outputs stay put through stalls and bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
      id   <= '0;
    end else if (adv) begin
      vld <= in_vld;
      if (in_vld) begin
        data <= in_data;
        id   <= in_id;
      end
    end
  end

endmodule

// File: rtl/log_adder_pipe.sv
// Two-stage valid/ready log-domain adder feeding the antilog converter.
// Stage 1 sums characteristics and fractions; stage 2 applies zero forcing and drives outputs.
module log_adder_pipe
  import log_adder_pipe_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      a_k,
  input  logic [T-2:0]    a_frac,
  input  logic            a_sign,
  input  logic            a_zero,
  input  logic [2:0]      b_k,
  input  logic [T-2:0]    b_frac,
  input  logic            b_sign,
  input  logic            b_zero,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [T+3:0]    log_result,
  output logic            out_sign,
  output logic            out_zero,
  output logic [ID_W-1:0] out_id
);

  function automatic log_prod_t log_add(input log_operand_t x, input log_operand_t y);
    log_prod_t       r;
    logic [K_W-1:0]  k_sum;
    logic [T-1:0]    f_sum;
    k_sum        = {1'b0, x.k} + {1'b0, y.k};
    f_sum        = {1'b0, x.frac} + {1'b0, y.frac};
    r.zero       = x.zero | y.zero;
    r.sign       = (x.sign ^ y.sign) & ~r.zero;
    r.log_result = {k_sum, f_sum};
    return r;
  endfunction

  // A zero product carries no meaningful log; hand the antilog stage a clean 0.
  function automatic log_prod_t force_zero(input log_prod_t p);
    log_prod_t r;
    r = p;
    if (p.zero) r.log_result = '0;
    return r;
  endfunction

  log_operand_t    op_a_p0, op_b_p0;
  log_prod_t       sum_p0, prod_p1, res_p1, prod_p2;
  logic [ID_W-1:0] id_p1, id_p2;
  logic            vld_p1, vld_p2;
  logic            adv_p1, adv_p2;

  assign op_a_p0 = '{k: a_k, frac: a_frac, sign: a_sign, zero: a_zero};
  assign op_b_p0 = '{k: b_k, frac: b_frac, sign: b_sign, zero: b_zero};
  assign sum_p0  = log_add(op_a_p0, op_b_p0);

  assign adv_p2   = ~vld_p2 | out_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign in_ready = adv_p1;

  // Stage 1 boundary: raw log sum
  pipe_reg_stage #(.ID_W(ID_W)) u_stage1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (adv_p1),
    .in_vld  (in_valid),
    .in_data (sum_p0),
    .in_id   (in_id),
    .vld     (vld_p1),
    .data    (prod_p1),
    .id      (id_p1)
  );

  assign res_p1 = force_zero(prod_p1);

  // Stage 2 boundary: output register
  pipe_reg_stage #(.ID_W(ID_W)) u_stage2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (adv_p2),
    .in_vld  (vld_p1),
    .in_data (res_p1),
    .in_id   (id_p1),
    .vld     (vld_p2),
    .data    (prod_p2),
    .id      (id_p2)
  );

  assign out_valid  = vld_p2;
  assign log_result = prod_p2.log_result;
  assign out_sign   = prod_p2.sign;
  assign out_zero   = prod_p2.zero;
  assign out_id     = id_p2;

endmodule

// File: tb/tb_log_adder_pipe.sv
// Scoreboard bench for log_adder_pipe: integer operands encoded by the bench, expected log sums queued on accept.
`timescale 1ns/1ps
module tb_log_adder_pipe;
  import log_adder_pipe_pkg::*;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      a_k = '0, b_k = '0;
  logic [T-2:0]    a_frac = '0, b_frac = '0;
  logic            a_sign = 1'b0, a_zero = 1'b0, b_sign = 1'b0, b_zero = 1'b0;
  logic [ID_W-1:0] in_id = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [T+3:0]    log_result;
  logic            out_sign, out_zero;
  logic [ID_W-1:0] out_id;

  int cur_a = 0, cur_b = 0;
  int n_chk = 0, n_pass = 0, cyc = 0;
  bit run_mon = 1'b0;
  bit rnd_done = 1'b0;

  typedef struct {
    logic [T+3:0]    lr;
    logic            s;
    logic            z;
    logic [ID_W-1:0] id;
    int              stamp;
  } exp_t;
  exp_t sb[$];

  log_adder_pipe #(.ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_k(a_k), .a_frac(a_frac), .a_sign(a_sign), .a_zero(a_zero),
    .b_k(b_k), .b_frac(b_frac), .b_sign(b_sign), .b_zero(b_zero),
    .in_id(in_id), .out_valid(out_valid), .out_ready(out_ready),
    .log_result(log_result), .out_sign(out_sign), .out_zero(out_zero), .out_id(out_id)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
  endfunction

  function automatic int ilog2(input int m);
    int k = 0;
    while ((m >> (k + 1)) != 0) k++;
    return k;
  endfunction

  // Mitchell fraction of m scaled to T-1 bits: (m / 2^k - 1) * 2^(T-1).
  function automatic int fracof(input int m);
    int k = ilog2(m);
    return (m - (1 << k)) << (T - 1 - k);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Plays the leading-one/log encoder; zero operands get random don't-care fields.
  task automatic enc(input int v, output logic [2:0] k, output logic [T-2:0] f,
                     output logic s, output logic z);
    int m, kk, ff;
    logic [31:0] r;
    m = iabs(v);
    r = $urandom;
    z = (m == 0);
    k = r[2:0];
    f = r[T+1:3];
    s = z ? r[T+2] : (v < 0);
    if (m != 0) begin
      kk = ilog2(m);
      ff = fracof(m);
      k  = kk[2:0];
      f  = ff[T-2:0];
    end
  endtask

  function automatic exp_t model(input int a, input int b, input logic [ID_W-1:0] id);
    exp_t e;
    int   ma, mb, v;
    ma = iabs(a);
    mb = iabs(b);
    e.id = id;
    e.stamp = cyc;
    if (ma == 0 || mb == 0) begin
      e.lr = '0;
      e.s  = 1'b0;
      e.z  = 1'b1;
    end else begin
      v    = ((ilog2(ma) + ilog2(mb)) << T) + fracof(ma) + fracof(mb);
      e.lr = v[T+3:0];
      e.s  = ((a < 0) != (b < 0));
      e.z  = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    logic ev;
    #4;
    if (run_mon && rst_n) begin
      cyc++;
      ev = (sb.size() > 0) && (cyc - sb[0].stamp >= 2);
      chk("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (out_valid && sb.size() > 0) begin
        chk("result{lr,sign,zero,id}", 32'({log_result, out_sign, out_zero, out_id}),
            32'({sb[0].lr, sb[0].s, sb[0].z, sb[0].id}));
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        e = model(cur_a, cur_b, in_id);
        sb.push_back(e);
      end
    end
  end

  task automatic send(input int a, input int b, input logic [ID_W-1:0] id);
    logic [2:0]   k;
    logic [T-2:0] f;
    logic         s, z;
    bit           took;
    took = 1'b0;
    enc(a, k, f, s, z);
    a_k = k; a_frac = f; a_sign = s; a_zero = z;
    enc(b, k, f, s, z);
    b_k = k; b_frac = f; b_sign = s; b_zero = z;
    cur_a = a; cur_b = b; in_id = id; in_valid = 1'b1;
    for (int i = 0; i < 100 && !took; i++) begin
      #4;
      took = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!took) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_log_result", 32'(log_result), 32'(0));
    chk("rst_side{sign,zero,id}", 32'({out_sign, out_zero, out_id}), 32'(0));
    rst_n = 1'b1;
    run_mon = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    send(3, 3, 4'd1);
    send(-5, 6, 4'd2);
    send(0, -127, 4'd3);
    send(-128, -128, 4'd4);
    send(127, -1, 4'd5);
    send(-64, 0, 4'd6);
    idle(4);

    fork
      begin
        for (int i = 0; i < 6; i++) send(i * 17 - 40, 90 - i * 23, 4'(i));
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(4);

    send(7, 9, 4'd10);
    send(-3, 100, 4'd11);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_out_valid", 32'(out_valid), 32'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(20, -30, 4'd12);
    idle(4);

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
          b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
          send(a, b, 4'(i));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/log_adder_pipe.md
Name: log_adder_pipe

Overview:
- Two-stage, valid/ready pipelined log-domain adder for the approximate 8x8 signed Mitchell multiplier.
- Sits directly upstream of the antilog converter:
  - consumes two log-encoded operand magnitudes from the leading-one/log encoders;
  - produces the `T+4`-bit `log_result` the antilog stage expects, plus sign, zero and tag side-band.
- Provides full backpressure so the multiplier datapath can stall without loss.

Parameters:
- T, `T (shared define), width of the log-sum fraction field. Operand fractions are T-1 bits; the sum's MSB is the fraction carry.
- ID_W, 4, width of the transaction tag passed through unchanged.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- a_k  in  3  characteristic (leading-one position) of |a|, range 0..7
- a_frac  in  T-1  mantissa fraction of |a|
- a_sign  in  1  sign of a
- a_zero  in  1  a == 0 (a_k/a_frac don't-care)
- b_k, b_frac, b_sign, b_zero  in  3/T-1/1/1  same meaning for operand b
- in_id  in  ID_W  transaction tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- log_result  out  T+4  {k_sum[3:0], x_t[T-1:0]} for the antilog converter
- out_sign  out  1  product sign
- out_zero  out  1  product is exactly zero; downstream forces result 0
- out_id  out  ID_W  tag of this result

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, log_result=0, out_sign=0, out_zero=0, out_id=0. in_ready=1 one cycle after release. Assertion mid-operation drops all in-flight pairs; nothing is replayed.
- Handshake:
  - Transfer occurs on in_valid&&in_ready, or on out_valid&&out_ready.
  - out_* are stable while out_valid=1 and out_ready=0.
  - in_valid may drop without a transfer.
- Stage 1 (S1) register captures:
  - zero_s1 = a_zero|b_zero
  - sign_s1 = (a_sign^b_sign) & ~zero_s1
  - k_s1 = a_k + b_k (4 bits, max 14, no overflow)
  - frac_s1 = a_frac + b_frac (T bits, zero-extended, carry lands in bit T-1)
  - id
- Stage 2 (S2) = output register:
  - log_result = zero ? 0 : {k_s1, frac_s1}
  - out_sign = sign_s1
  - out_zero = zero_s1
  - out_id = id_s1
- Advance rules:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
- Latency: 2 cycles accept-to-out_valid with no stall. Throughput 1/cycle.
- Stall: when out_ready=0 with both stages full, in_ready=0 and both stages hold. When out_ready returns to 1, both stages shift in the same cycle and a new input is accepted that cycle (no bubble).
- Simultaneous accept and drain: S1→S2 and in→S1 in the same edge. A valid S1 entry is never overwritten while S2 is blocked.
- Order preserved; out_id sequence equals in_id sequence.
- Zero operand: log_result forced to 0 and out_sign=0, regardless of the other operand or the signs.

Decomposition:
- Shared package (alongside the `T define) holds:
  - typedef log_operand_t {k[2:0], frac[T-2:0], sign, zero}
  - typedef log_prod_t {log_result[T+3:0], sign, zero}
  - constant K_W=4
- One natural sub-module: pipe_reg_stage (valid/ready-gated register holding a log_prod_t plus tag), instantiated twice. The adder logic stays in the top level.

Test Plan:
- Tests use T=8 (7-bit fractions).
- Basic Mitchell sum: a=3 (k=1, frac=0x40), b=3 (k=1, frac=0x40), out_ready=1 → 2 cycles later log_result={4'd2, 8'h80}, sign=0, zero=0. The antilog stage then yields 8.
- Sign and no-carry: a=-5 (k=2, frac=0x20, sign=1), b=6 (k=2, frac=0x40) → log_result={4'd4, 8'h60}, out_sign=1.
- Zero: a_zero=1, b=-127 → out_zero=1, log_result=0, out_sign=0.
- Backpressure:
  - Stream ids 0..5 back-to-back, hold out_ready=0 for cycles 3..7.
  - in_ready falls once both stages are full.
  - No drop or duplicate; out_id order 0..5; outputs stable while stalled.
  - Release yields one result/cycle with no bubble.
- Max range: a=-128, b=-128 (k=7, frac=0) → log_result={4'd14, 8'h00}, sign=0.
- Reset mid-stream: assert rst_n low with 2 entries in flight → out_valid=0 immediately (async). After release, the first output is the first post-reset input at 2-cycle latency.
